engine_memory_arbiter: RTL
==========================

# engine_memory_arbiter

Shares one instruction-memory read port among `2**ENGINE_ID_BITS` engines. Each engine issues single outstanding fetch requests; the arbiter grants them round-robin onto the memory port and tracks in-flight requests in an ID/address FIFO. It routes each in-order response back to its requester and broadcasts the fetched address and data to all engines for cache fill. It sits between the engine array and the instruction memory in the coprocessor.

## Interface
- `ENGINE_ID_BITS`, 2: log2 of the number of requesters N.
- `MEMORY_WIDTH`, 16: instruction word width.
- `MEMORY_ADDR_WIDTH`, 11: address width.
- `OUTSTANDING_BITS`, 2: log2 of the in-flight FIFO depth D.

Ports:
- `clk`  in  1  clock; all state on rising edge.
- `rst`  in  1  reset, asynchronous and active-low.
- `req_valid`  in  N  per-engine fetch request; held high until that engine's `rsp_valid` pulse.
- `req_addr`  in  N*MEMORY_ADDR_WIDTH  per-engine address; stable while `req_valid` is high.
- `rsp_valid`  out  N  one-cycle pulse to the served engine(s).
- `rsp_data`  out  MEMORY_WIDTH  data shared by all engines; valid with any `rsp_valid` bit.
- `broadcast_valid`  out  1  one-cycle pulse on every response.
- `broadcast_addr`  out  MEMORY_ADDR_WIDTH  address of the broadcast word.
- `mem_valid`  out  1  memory request valid.
- `mem_addr`  out  MEMORY_ADDR_WIDTH  memory request address.
- `mem_ready`  in  1  memory accepts the request when `mem_valid && mem_ready`.
- `mem_rsp_valid`  in  1  memory response; responses return in request order.
- `mem_rsp_data`  in  MEMORY_WIDTH  response data.
- `orphan_err`  out  1  sticky flag: a response arrived while the FIFO was empty.

## Operation
- **Per-engine state:** one `issued` bit per engine. Set on the grant to that engine. Cleared when that engine's `rsp_valid` pulses.
- **Candidates:** `req_valid & ~issued`.
- **Round-robin arbitration:**
  - `rr_ptr` holds the last granted ID; priority starts at `rr_ptr+1` and wraps modulo N.
  - A grant is made only when the issue register is free (`!mem_valid`, or `mem_valid && mem_ready` this cycle) and the FIFO is not full.
  - A grant loads `mem_valid`=1 and `mem_addr`, pushes {ID, addr} into the FIFO, sets `issued[ID]` and updates `rr_ptr`.
- **Issue register:** holds `mem_valid`/`mem_addr` until accepted. With no new grant on the accept cycle, `mem_valid` falls.
- **In-flight FIFO:** depth D; counter width OUTSTANDING_BITS+1; pointers wrap modulo D.
  - Push and pop in the same cycle are legal at any occupancy, including full; the count is unchanged.
- **Response path:** on `mem_rsp_valid` with the FIFO non-empty:
  - Pop the FIFO head.
  - Next cycle: `rsp_valid[head.ID]`=1, `rsp_data`=`mem_rsp_data`, `broadcast_valid`=1, `broadcast_addr`=head.addr.
- **Orphan response:** `mem_rsp_valid` with the FIFO empty is dropped and sets `orphan_err`. Only reset clears the flag.
- **Protocol violation:** an engine dropping `req_valid` while `issued` is set is illegal. Its response is still delivered and its `issued` bit cleared.

## Timing
- **Reset values:** all outputs 0. `rr_ptr`=N-1, so ID 0 has first priority. FIFO empty; `issued`=0.
- **Request to memory:** `req_valid` rising at cycle t gives `mem_valid` at t+1 when uncontested and the port is free.
- **Response to engine:** `mem_rsp_valid` at cycle t gives `rsp_valid` at t+1. Other response outputs are pulses of exactly one cycle.
- **Throughput:** one grant per cycle while `mem_ready`=1 and the FIFO is not full.
- **Reset mid-operation:**
  - Asserting reset immediately clears the FIFO, `issued`, `mem_valid` and the response outputs.
  - Responses for requests issued before reset raise `orphan_err`.
  - Engines must re-request after reset.

## Configuration
- `ARBITER_COALESCE_EN`
  - **Defined:** in the response cycle, every engine with `req_valid && !issued && req_addr == head.addr` also receives `rsp_valid` with the same data. Those engines are masked out of arbitration in that cycle.
  - **Undefined:** only `head.ID` receives `rsp_valid`; matching pending requests are arbitrated normally.

## Test plan
- **Reset values:** assert reset with N=4 -> all outputs 0. Release, raise `req_valid[0]` with addr 0x010 -> `mem_valid`=1, `mem_addr`=0x010 one cycle later.
- **Round-robin fairness:** all four engines request continuously with `mem_ready`=1 and memory latency 3 -> grants in order 0,1,2,3, each response reaching the matching engine one cycle after `mem_rsp_valid`.
- **Backpressure:** hold `mem_ready`=0 for 5 cycles -> `mem_valid`/`mem_addr` stable, no extra FIFO push. With D=4 and 4 responses withheld -> no fifth grant; a pop and grant in the same cycle keeps the count at 4.
- **Orphan response:** `mem_rsp_valid` with the FIFO empty -> no `rsp_valid`, `orphan_err`=1 until reset.
- **Coalescing (macro defined):** engine 1 is in flight at 0x020 and engine 2 requests 0x020 -> both `rsp_valid[1]` and `rsp_valid[2]` pulse with the same data, and engine 2 is never granted. Without the macro, engine 2 is granted separately.
- **Reset during traffic:** assert reset with 3 requests in flight -> FIFO empty and outputs 0. A late `mem_rsp_valid` after release -> `orphan_err`=1.

Source files
------------

// File: rtl/engine_memory_arbiter.sv
// rtl/engine_memory_arbiter.sv - round-robin engine fetch arbiter with in-flight FIFO; optional ARBITER_COALESCE_EN
module engine_memory_arbiter #(
    parameter int ENGINE_ID_BITS    = 2,
    parameter int MEMORY_WIDTH      = 16,
    parameter int MEMORY_ADDR_WIDTH = 11,
    parameter int OUTSTANDING_BITS  = 2
) (
    input  logic                                          clk,
    input  logic                                          rst,
    input  logic [(1<<ENGINE_ID_BITS)-1:0]                req_valid,
    input  logic [(1<<ENGINE_ID_BITS)*MEMORY_ADDR_WIDTH-1:0] req_addr,
    output logic [(1<<ENGINE_ID_BITS)-1:0]                rsp_valid,
    output logic [MEMORY_WIDTH-1:0]                       rsp_data,
    output logic                                          broadcast_valid,
    output logic [MEMORY_ADDR_WIDTH-1:0]                  broadcast_addr,
    output logic                                          mem_valid,
    output logic [MEMORY_ADDR_WIDTH-1:0]                  mem_addr,
    input  logic                                          mem_ready,
    input  logic                                          mem_rsp_valid,
    input  logic [MEMORY_WIDTH-1:0]                       mem_rsp_data,
    output logic                                          orphan_err
);
    localparam int N = 1 << ENGINE_ID_BITS;
    localparam int D = 1 << OUTSTANDING_BITS;
    localparam logic [OUTSTANDING_BITS:0]   FIFO_DEPTH = (OUTSTANDING_BITS+1)'(D);
    localparam logic [OUTSTANDING_BITS:0]   CNT_ONE    = (OUTSTANDING_BITS+1)'(1);
    localparam logic [OUTSTANDING_BITS-1:0] PTR_ONE    = OUTSTANDING_BITS'(1);
    localparam logic [ENGINE_ID_BITS-1:0]   LAST_ID    = '1;

    logic [N-1:0]                  issued;
    logic [ENGINE_ID_BITS-1:0]     rr_ptr;
    logic [ENGINE_ID_BITS-1:0]     fifo_id   [D];
    logic [MEMORY_ADDR_WIDTH-1:0]  fifo_addr [D];
    logic [OUTSTANDING_BITS-1:0]   wr_ptr;
    logic [OUTSTANDING_BITS-1:0]   rd_ptr;
    logic [OUTSTANDING_BITS:0]     count;

    logic                          fifo_empty;
    logic                          fifo_full;
    logic                          pop;
    logic                          issue_free;
    logic [ENGINE_ID_BITS-1:0]     head_id;
    logic [MEMORY_ADDR_WIDTH-1:0]  head_addr;
    logic [N-1:0]                  coal_mask;
    logic [N-1:0]                  cand;
    logic                          grant;
    logic [ENGINE_ID_BITS-1:0]     grant_id;
    logic [ENGINE_ID_BITS-1:0]     idx;
    logic [N-1:0]                  grant_onehot;
    logic [MEMORY_ADDR_WIDTH-1:0]  grant_addr;

    assign fifo_empty = (count == '0);
    assign pop        = mem_rsp_valid && !fifo_empty;
    assign head_id    = fifo_id[rd_ptr];
    assign head_addr  = fifo_addr[rd_ptr];
    // A pop frees a slot in the same cycle, so a full FIFO can still accept a push.
    assign fifo_full  = (count == FIFO_DEPTH) && !pop;
    assign issue_free = !mem_valid || mem_ready;
    assign grant_addr = req_addr[grant_id*MEMORY_ADDR_WIDTH +: MEMORY_ADDR_WIDTH];

    // Engines asking for the word being returned right now are served from the broadcast.
    always_comb begin
        coal_mask = '0;
`ifdef ARBITER_COALESCE_EN
        for (int i = 0; i < N; i++) begin
            if (pop && req_valid[i] && !issued[i] && !rsp_valid[i] &&
                req_addr[i*MEMORY_ADDR_WIDTH +: MEMORY_ADDR_WIDTH] == head_addr)
                coal_mask[i] = 1'b1;
        end
`endif
    end

    // Round-robin search starting one past the last granted engine.
    always_comb begin
        cand         = req_valid & ~issued & ~rsp_valid & ~coal_mask;
        grant        = 1'b0;
        grant_id     = '0;
        idx          = '0;
        grant_onehot = '0;
        if (issue_free && !fifo_full) begin
            for (int k = 1; k <= N; k++) begin
                idx = rr_ptr + ENGINE_ID_BITS'(k);
                if (!grant && cand[idx]) begin
                    grant    = 1'b1;
                    grant_id = idx;
                end
            end
        end
        if (grant)
            grant_onehot = N'(1) << grant_id;
    end

    // Arbitration, issue register, FIFO pointers and response outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            issued          <= '0;
            rr_ptr          <= LAST_ID;
            wr_ptr          <= '0;
            rd_ptr          <= '0;
            count           <= '0;
            mem_valid       <= 1'b0;
            mem_addr        <= '0;
            rsp_valid       <= '0;
            rsp_data        <= '0;
            broadcast_valid <= 1'b0;
            broadcast_addr  <= '0;
            orphan_err      <= 1'b0;
        end else begin
            issued <= (issued & ~rsp_valid) | grant_onehot;
            if (grant) begin
                mem_valid <= 1'b1;
                mem_addr  <= grant_addr;
                rr_ptr    <= grant_id;
                wr_ptr    <= wr_ptr + PTR_ONE;
            end else if (mem_ready) begin
                mem_valid <= 1'b0;
            end
            if (pop)
                rd_ptr <= rd_ptr + PTR_ONE;
            if (grant && !pop)
                count <= count + CNT_ONE;
            else if (!grant && pop)
                count <= count - CNT_ONE;
            broadcast_valid <= pop;
            if (pop) begin
                rsp_valid      <= (N'(1) << head_id) | coal_mask;
                rsp_data       <= mem_rsp_data;
                broadcast_addr <= head_addr;
            end else begin
                rsp_valid <= '0;
            end
            if (mem_rsp_valid && fifo_empty)
                orphan_err <= 1'b1;
        end
    end

    // FIFO storage needs no reset; the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (grant) begin
            fifo_id[wr_ptr]   <= grant_id;
            fifo_addr[wr_ptr] <= grant_addr;
        end
    end
endmodule
